// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

    localparam int SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sub_state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, bout set when the bit underflows.
module full_subtractor (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = x_i ^ y_i ^ bin_i;
    assign bout_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, LSB first, one bit per clock.
// Handshake: start is taken only while busy=0; done pulses once when diff/borrow_out update.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output sub_state_e       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .x_i   (a_q[0]),
        .y_i   (b_q[0]),
        .bin_i (brw_q),
        .d_o   (cell_d),
        .bout_o(cell_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    brw_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Result fills from the MSB, so after WIDTH shifts it is already aligned.
                a_d               = a_q >> 1;
                b_d               = b_q >> 1;
                res_d             = res_q >> 1;
                res_d[WIDTH-1]    = cell_d;
                brw_d             = cell_bout;
                cnt_d             = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                diff_d  = res_q;
                bout_d  = brw_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle model plus result scoreboard (WIDTH=8 and WIDTH=1).
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int W = 8;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // WIDTH=8 instance
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out;
    logic [W-1:0] diff;
    sub_state_e   state_dbg;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow_out(borrow_out),
        .state_dbg (state_dbg)
    );

    // WIDTH=1 instance
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, borrow1;
    logic [0:0] diff1;
    sub_state_e state1_dbg;

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .a         (a1),
        .b         (b1),
        .busy      (busy1),
        .done      (done1),
        .diff      (diff1),
        .borrow_out(borrow1),
        .state_dbg (state1_dbg)
    );

    int vectors = 0;
    int misses  = 0;
    int n_done  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            misses++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model: remaining busy cycles, expected results {borrow, diff}
    logic [W:0] exp_q[$];
    logic [1:0] exp1_q[$];
    int         rem = 0;
    bit         done_exp = 1'b0;
    logic [W:0] hold_exp = '0;

    always @(posedge clk) begin
        logic [W-1:0] d_m;
        logic         b_m;
        done_exp = 1'b0;
        if (rst) begin
            rem = 0;
            exp_q.delete();
            hold_exp = '0;
        end else if (rem == 0) begin
            if (start) begin
                d_m = a - b;
                b_m = (a < b);
                exp_q.push_back({b_m, d_m});
                rem = W + 1;
            end
        end else begin
            rem--;
            if (rem == 0) done_exp = 1'b1;
        end
    end

    // scoreboard / monitor, sampled away from the active edge
    always @(negedge clk) begin
        logic [W:0] e;
        sub_state_e st_exp;
        st_exp = (rem == 0) ? ST_IDLE : ((rem == 1) ? ST_SHIFT : ST_SHIFT);
        if (rem == 1) st_exp = ST_DONE;
        check_eq("busy", 32'(busy), 32'(rem != 0));
        check_eq("done", 32'(done), 32'(done_exp));
        check_eq("state", 32'(state_dbg), 32'(st_exp));
        if (done) n_done++;
        if (done_exp) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_eq("diff", 32'(diff), 32'(e[W-1:0]));
                check_eq("borrow_out", 32'(borrow_out), 32'(e[W]));
                hold_exp = e;
            end
        end else begin
            check_eq("diff_hold", 32'(diff), 32'(hold_exp[W-1:0]));
            check_eq("borrow_hold", 32'(borrow_out), 32'(hold_exp[W]));
        end
    end

    // driver tasks
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        start_op(x, y);
        repeat (W + 1) @(negedge clk);
    endtask

    task automatic op1(input logic x, input logic y);
        logic [0:0] d1;
        logic [1:0] e1;
        d1 = x - y;
        @(negedge clk);
        start1 = 1'b1;
        a1 = x;
        b1 = y;
        exp1_q.push_back({(~x & y), d1});
        @(negedge clk);
        start1 = 1'b0;
        a1 = ~x;
        b1 = ~y;
        check_eq("w1_busy_shift", 32'(busy1), 32'd1);
        check_eq("w1_done_early", 32'(done1), 32'd0);
        @(negedge clk);
        check_eq("w1_busy_done", 32'(busy1), 32'd1);
        @(negedge clk);
        check_eq("w1_done", 32'(done1), 32'd1);
        check_eq("w1_busy_low", 32'(busy1), 32'd0);
        e1 = exp1_q.pop_front();
        check_eq("w1_diff", 32'(diff1), 32'(e1[0]));
        check_eq("w1_borrow", 32'(borrow1), 32'(e1[1]));
        @(negedge clk);
        check_eq("w1_done_pulse", 32'(done1), 32'd0);
        check_eq("w1_diff_hold", 32'(diff1), 32'(e1[0]));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_diff", 32'(diff), 32'd0);
        check_eq("rst_borrow", 32'(borrow_out), 32'd0);
        check_eq("rst_w1_busy", 32'(busy1), 32'd0);
        rst = 1'b0;

        // directed operands
        run_op(8'h35, 8'h12);
        run_op(8'h00, 8'h01);
        run_op(8'hA5, 8'hA5);
        run_op(8'hFF, 8'h00);

        // start while busy is ignored
        start_op(8'h35, 8'h12);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a = 8'h77;
        b = 8'h11;
        @(negedge clk);
        start = 1'b0;
        repeat (W) @(negedge clk);

        // reset in the 4th SHIFT cycle aborts the operation
        start_op(8'hC3, 8'h5A);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_diff", 32'(diff), 32'd0);
        run_op(8'h10, 8'h20);

        // start held high: one result every W+2 cycles
        @(negedge clk);
        start = 1'b1;
        a = 8'h09;
        b = 8'h03;
        repeat (2 * (W + 2) + 1) @(negedge clk);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        // random operands
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end
        repeat (2) @(negedge clk);

        // WIDTH=1 truth table
        op1(1'b0, 1'b0);
        op1(1'b0, 1'b1);
        op1(1'b1, 1'b0);
        op1(1'b1, 1'b1);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        check_eq("done_count", 32'(n_done), 32'd15);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
